// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC sequencing, branch/jump redirect, stall and a write-loadable instruction memory.
// Optional build macro IFETCH_MISALIGN_CHECK_EN halts on misaligned redirect targets and adds the misalign port.
module instr_fetch #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  zero,
    input  logic                  jump,
    input  logic [31:0]           target,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic [31:0]           pc,
    output logic [31:0]           instruction,
    output logic [31:0]           pc_plus4,
    output logic                  valid
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    output logic                  misalign
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_LOAD,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        mem_we;
    logic        taken;

    logic [31:0] imem [0:(1<<DEPTH_LOG2)-1];

    assign taken = jump | (branch & zero);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        mem_we     = 1'b0;
        case (state_q)
            S_BOOT: begin
                pc_d    = RESET_PC;
                instr_d = imem[RESET_PC[DEPTH_LOG2+1:2]];
                valid_d = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (load_en) begin
                    mem_we  = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_LOAD;
                end else if (stall) begin
                    valid_d = 1'b1;
                end else if (taken) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
                    if (target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        valid_d    = 1'b0;
                        pc_d       = target;
                        state_d    = S_HALT;
                    end else begin
                        pc_d    = target;
                        instr_d = imem[target[DEPTH_LOG2+1:2]];
                        valid_d = 1'b1;
                    end
`else
                    // Low target bits are dropped so the PC always stays word aligned.
                    pc_d    = target & ~32'h3;
                    instr_d = imem[target[DEPTH_LOG2+1:2]];
                    valid_d = 1'b1;
`endif
                end else begin
                    pc_d    = pc_q + 32'd4;
                    instr_d = imem[pc_d[DEPTH_LOG2+1:2]];
                    valid_d = 1'b1;
                end
            end
            S_LOAD: begin
                valid_d = 1'b0;
                if (load_en) begin
                    mem_we = 1'b1;
                end else begin
                    state_d = S_BOOT;
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            imem[load_addr] <= load_data;
        end
    end

    assign pc          = pc_q;
    assign instruction = instr_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign valid       = valid_q;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign misalign = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized checking of instr_fetch against a behavioural fetch model.
module tb_instr_fetch;

    localparam int          D     = 8;
    localparam int          WORDS = 1 << D;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst, stall, branch, zero, jump, load_en;
    logic [31:0]  target, load_data;
    logic [D-1:0] load_addr;
    logic [31:0]  pc, instruction, pc_plus4;
    logic         valid;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic         misalign;
`endif

    instr_fetch #(.DEPTH_LOG2(D), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .zero(zero),
        .jump(jump), .target(target), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .pc(pc), .instruction(instruction),
        .pc_plus4(pc_plus4), .valid(valid)
`ifdef IFETCH_MISALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: memory image plus what the fetch unit is currently doing.
    logic [31:0] mem_m [WORDS];
    logic [31:0] pc_m, instr_m;
    logic        valid_m, mis_m;
    bit          booting, loading, halted;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fetch(input logic [31:0] addr);
        return mem_m[(addr / 4) % WORDS];
    endfunction

    task automatic model_edge();
        logic [31:0] np;
        if (rst) begin
            booting = 1; loading = 0; halted = 0;
            pc_m = RPC; instr_m = NOP; valid_m = 0; mis_m = 0;
        end else if (halted) begin
            valid_m = 0;
        end else if (booting) begin
            booting = 0;
            pc_m = RPC; instr_m = fetch(RPC); valid_m = 1;
        end else if (loading) begin
            valid_m = 0;
            if (load_en) mem_m[load_addr] = load_data;
            else begin loading = 0; booting = 1; end
        end else if (load_en) begin
            mem_m[load_addr] = load_data;
            valid_m = 0; loading = 1;
        end else if (stall) begin
            valid_m = 1;
        end else if (jump || (branch && zero)) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (target % 4 != 0) begin
                mis_m = 1; valid_m = 0; pc_m = target; halted = 1;
            end else begin
                pc_m = target; instr_m = fetch(target); valid_m = 1;
            end
`else
            np = target - (target % 4);
            pc_m = np; instr_m = fetch(np); valid_m = 1;
`endif
        end else begin
            np = pc_m + 4;
            pc_m = np; instr_m = fetch(np); valid_m = 1;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".pc"}, pc, pc_m);
        chk({tag, ".instr"}, instruction, instr_m);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, valid_m});
        chk({tag, ".pc4"}, pc_plus4, pc_m + 32'd4);
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk({tag, ".mis"}, {31'd0, misalign}, {31'd0, mis_m});
`endif
    endtask

    task automatic idle_inputs();
        stall = 0; branch = 0; zero = 0; jump = 0; target = 0;
        load_en = 0; load_addr = '0; load_data = 0;
    endtask

    logic [31:0] prog [4];
    logic [31:0] save_pc, save_instr;

    initial begin
        prog[0] = 32'h0010_0093; prog[1] = 32'h0020_0113;
        prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;
        idle_inputs();
        rst = 1;
        step("reset0");
        step("reset1");
        chk("reset.instr_nop", instruction, NOP);
        chk("reset.valid_low", {31'd0, valid}, 32'd0);

        rst = 0;
        step("boot");
        chk("boot.valid_high", {31'd0, valid}, 32'd1);

        // Fill the whole memory; the first four words form a small program.
        for (int i = 0; i < WORDS; i++) begin
            load_en = 1; load_addr = D'(i);
            load_data = (i < 4) ? prog[i] : $urandom;
            step("load");
        end
        load_en = 0;
        step("load_exit_bubble");
        chk("bubble.valid_low", {31'd0, valid}, 32'd0);
        step("refetch0");
        chk("prog.w0", instruction, 32'h0010_0093);
        step("refetch1");
        chk("prog.w1", instruction, 32'h0020_0113);
        chk("prog.pc1", pc, 32'h4);

        jump = 1; target = 32'hC;
        step("jump_c");
        chk("jump.pc", pc, 32'hC);
        chk("jump.instr", instruction, 32'h0000_0013);
        jump = 0; branch = 1; zero = 0;
        step("branch_not_taken");
        chk("bnt.pc", pc, 32'h10);

        zero = 1; target = 32'h40; stall = 1;
        save_pc = pc; save_instr = instruction;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall.pc_held", pc, save_pc);
        chk("stall.instr_held", instruction, save_instr);
        stall = 0; branch = 0; zero = 0;
        step("stall_release");
        chk("release.pc", pc, save_pc + 32'd4);

        jump = 1; target = 32'h3FC;
        step("jump_3fc");
        jump = 0;
        step("wrap_mem");
        chk("wrap.pc", pc, 32'h400);
        chk("wrap.instr", instruction, 32'h0010_0093);

        jump = 1; target = 32'hFFFF_FFFC;
        step("jump_top");
        chk("top.pc4_wrap", pc_plus4, 32'h0);
        jump = 0;
        step("pc_wrap");
        chk("pcwrap.pc", pc, 32'h0);

        // Reset in the middle of a load burst; written words must persist.
        load_en = 1; load_addr = 8'd5; load_data = 32'hCAFE_0005;
        step("midload_w5");
        load_addr = 8'd6; load_data = 32'hCAFE_0006;
        step("midload_w6");
        rst = 1; load_addr = 8'd7; load_data = 32'hDEAD_0007;
        step("midload_rst");
        chk("midrst.instr", instruction, NOP);
        chk("midrst.valid", {31'd0, valid}, 32'd0);
        rst = 0; load_en = 0;
        step("midrst_boot");
        jump = 1; target = 32'h14;
        step("fetch_w5");
        chk("retain.w5", instruction, 32'hCAFE_0005);
        jump = 0;
        step("fetch_w6");
        chk("retain.w6", instruction, 32'hCAFE_0006);

        jump = 1; target = 32'h6;
        step("misalign_jump");
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("mis.flag", {31'd0, misalign}, 32'd1);
        jump = 0;
        for (int i = 0; i < 3; i++) step("halt_hold");
        chk("halt.valid", {31'd0, valid}, 32'd0);
        rst = 1;
        step("halt_rst");
        rst = 0;
        step("halt_reboot");
`else
        chk("mis.align_pc", pc, 32'h4);
        jump = 0;
`endif

        for (int i = 0; i < 400; i++) begin
            stall  = ($urandom_range(0, 3) == 0);
            branch = $urandom_range(0, 1) == 1;
            zero   = $urandom_range(0, 1) == 1;
            jump   = ($urandom_range(0, 4) == 0);
            target = $urandom;
`ifdef IFETCH_MISALIGN_CHECK_EN
            target = target & ~32'h3;
`endif
            load_en   = ($urandom_range(0, 9) == 0) || (loading && $urandom_range(0, 1) == 1);
            load_addr = D'($urandom);
            load_data = $urandom;
            rst       = ($urandom_range(0, 59) == 0);
            step("rand");
        end
        idle_inputs();
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning instruction memory holds 2^DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset or load.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port stall, input, 1, holding pc/instruction when high.
REQ-006 SHALL have port branch, input, 1, conditional-branch request from the controller.
REQ-007 SHALL have port zero, input, 1, ALU zero flag qualifying branch.
REQ-008 SHALL have port jump, input, 1, unconditional redirect (jal/jalr).
REQ-009 SHALL have port target, input, 32, redirect address from the ALU.
REQ-010 SHALL have ports load_en (input, 1), load_addr (input, DEPTH_LOG2, word index) and load_data (input, 32), forming the memory write port.
REQ-011 SHALL have ports pc (output, 32), instruction (output, 32), pc_plus4 (output, 32, combinational pc+4) and valid (output, 1, instruction/pc pair usable).
REQ-012 SHALL have port misalign, output, 1, sticky misaligned-target flag (present only per REQ-030).

Function
REQ-013 SHALL implement FSM states BOOT, RUN, LOAD, HALT.
REQ-014 BOOT: pc<=RESET_PC, instruction<=imem[RESET_PC word index], valid<=1, next RUN; one cycle, stall ignored.
REQ-015 RUN: taken = jump | (branch & zero); stall and load_en low -> pc<=taken ? target : pc+4, instruction<=imem[new pc word index] on the same edge.
REQ-016 pc and instruction SHALL always change on the same edge; instruction is exactly imem at pc's word index, zero-latency pairing.
REQ-017 RUN with stall high SHALL hold pc, instruction, valid=1; branch/jump ignored that cycle.
REQ-018 Priority in RUN: load_en > stall > redirect > sequential.
REQ-019 Word index = pc[DEPTH_LOG2+1:2]; upper pc bits kept in pc but ignored for lookup (address wraps modulo memory size).
REQ-020 pc+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
REQ-021 RUN with load_en high -> LOAD, valid<=0 the same edge.
REQ-022 LOAD: every cycle load_en is high writes imem[load_addr]<=load_data; outputs pc/instruction hold, valid=0.
REQ-023 LOAD with load_en low -> BOOT (one bubble, then refetch from RESET_PC); stall ignored in LOAD.
REQ-024 Write and fetch to same word in one cycle cannot occur (fetch frozen in LOAD); no bypass required.
REQ-025 HALT: valid=0, pc/instruction held, exit only by rst.

Reset
REQ-026 rst high at a rising edge SHALL force state BOOT, pc=RESET_PC, instruction=32'h0000_0013 (NOP), valid=0, misalign=0, overriding all other inputs including mid-LOAD.
REQ-027 rst SHALL NOT clear imem contents.
REQ-028 First cycle after rst falls executes BOOT; valid=1 visible after that edge.

Configuration
REQ-029 Macro IFETCH_MISALIGN_CHECK_EN SHALL select target alignment handling.
REQ-030 Defined: taken redirect with target[1:0]!=0 -> misalign<=1, valid<=0, pc<=target, state HALT; misalign port present.
REQ-031 Undefined: target[1:0] forced to 2'b00 on redirect, no HALT, misalign port absent.

Verification
REQ-032 Load words 0..3 = 0x00100093, 0x00200113, 0x002081B3, 0x00000013, drop load_en -> 1 bubble, then pc/instruction 0/0x00100093, 4/0x00200113, 8/0x002081B3, valid=1.
REQ-033 At pc=4, jump=1, target=0xC -> next edge pc=0xC, instruction=imem[3]; branch=1, zero=0 -> pc=pc+4.
REQ-034 stall=1 for 3 cycles with branch=1, zero=1 -> pc/instruction unchanged, no redirect; release -> sequential advance.
REQ-035 DEPTH_LOG2=8, pc=0x3FC sequential -> pc=0x400, instruction=imem[0].
REQ-036 rst mid-LOAD after 2 writes -> next edge valid=0, instruction=0x00000013; written words retained on later fetch.
REQ-037 With IFETCH_MISALIGN_CHECK_EN, jump target=0x6 -> misalign=1, valid=0, held until rst; without macro -> pc=0x4.
